cva6_rvfi_probe_tracker: RTL and testbench
==========================================

// Module: cva6_rvfi_probe_tracker
// PURPOSE
//  Consumer side of the RVFI probe bundle: takes the unpacked issue, LSU and commit probe fields and rebuilds
//  per-instruction RVFI retirement records. Holds a per-transaction-ID shadow table filled at issue and LSU time and read
//  at commit; emits one registered record per commit port. Sits in the verification-only RVFI path beside the core.
// PARAMETERS
//  NR_SB_ENTRIES    8   scoreboard depth = shadow table entries
//  TRANS_ID_BITS    3   log2(NR_SB_ENTRIES)
//  NR_COMMIT_PORTS  2   commit ports / record lanes
//  XLEN             64  register width; PLEN 56 physical address width
// PORTS
//  clk_i             in   1                     clock
//  rst_i             in   1                     synchronous active-high reset
//  flush_i           in   1                     pipeline flush; invalidates all table entries
//  issue_ack_i       in   1                     instruction issued this cycle
//  issue_pointer_i   in   TRANS_ID_BITS         trans ID of issued instruction
//  instruction_i     in   32                    raw instruction word (compressed in [15:0])
//  is_compressed_i   in   1                     issued instruction is RVC
//  rs1_fwd_i/rs2_fwd_i in XLEN                  operand values at issue
//  lsu_valid_i       in   1                     LSU request probe valid
//  lsu_trans_id_i    in   TRANS_ID_BITS         trans ID of LSU op
//  lsu_vaddr_i       in   XLEN                  virtual address;  lsu_paddr_i in PLEN physical address
//  lsu_be_i          in   8                     byte enables;  lsu_is_store_i in 1  store (1) / load (0)
//  commit_ack_i      in   NR_COMMIT_PORTS       per-port retirement
//  commit_pointer_i  in   NR_COMMIT_PORTS*TRANS_ID_BITS  trans ID per port
//  commit_pc_i       in   NR_COMMIT_PORTS*XLEN  PC per port;  commit_rd_i in NR_COMMIT_PORTS*5
//  commit_wdata_i    in   NR_COMMIT_PORTS*XLEN  writeback data per port
//  ex_valid_i        in   1                     exception on port 0;  ex_cause_i in XLEN cause
//  priv_lvl_i        in   2                     current privilege;  debug_mode_i in 1
//  rvfi_valid_o      out  NR_COMMIT_PORTS       record valid per lane
//  rvfi_order_o      out  NR_COMMIT_PORTS*64    retirement sequence number
//  rvfi_insn_o       out  NR_COMMIT_PORTS*32    instruction word (upper 16 zeroed if RVC)
//  rvfi_trap_o       out  NR_COMMIT_PORTS       lane trapped;  rvfi_cause_o out NR_COMMIT_PORTS*XLEN
//  rvfi_pc_o, rvfi_rs1_o, rvfi_rs2_o, rvfi_rd_wdata_o  out  NR_COMMIT_PORTS*XLEN each
//  rvfi_rd_addr_o    out  NR_COMMIT_PORTS*5;  rvfi_mode_o out NR_COMMIT_PORTS*2;  rvfi_dbg_o out NR_COMMIT_PORTS
//  rvfi_mem_addr_o   out  NR_COMMIT_PORTS*XLEN;  rvfi_mem_paddr_o NR_COMMIT_PORTS*PLEN
//  rvfi_mem_rmask_o/rvfi_mem_wmask_o  out  NR_COMMIT_PORTS*8
//  err_o             out  1                     sticky: commit read an invalid entry
// BEHAVIOUR
//  - Reset: all outputs 0, order counter 0, all entry valid bits 0, err_o 0.
//  - Issue write (issue_ack_i): entry[issue_pointer_i] <= insn, rvc, rs1, rs2; mem fields cleared; valid<=1.
//  - LSU write (lsu_valid_i): entry[lsu_trans_id_i] mem_addr/paddr set; wmask=be if store else rmask=be (other 0).
//    Same ID as issue write same cycle: issue wins.
//  - Commit lane i fires if commit_ack_i[i], or i==0 && ex_valid_i. Reads entry[commit_pointer_i[i]]; LSU write to
//    same ID same cycle is forwarded into the read. Record registered: 1-cycle latency, rvfi_valid_o pulses 1 cycle.
//  - Fired lane clears the entry valid bit. Acks contiguous from port 0 (ack[1] without ack[0] illegal; assertion).
//  - Order: lane i gets order_q + number of fired lanes below i; order_q += fired-lane count; wraps at 2^64.
//  - Exception lane 0: trap=1, cause=ex_cause_i, rd_addr=0, rd_wdata=0; lanes>0 not fired that cycle.
//  - rd_wdata forced 0 when rd==0. mode=priv_lvl_i, dbg=debug_mode_i sampled at commit.
//  - Invalid entry at commit: record still emitted with insn=0, rs1/rs2=0, mem fields 0; err_o set, held until reset.
//  - flush_i: commit reads of that cycle complete first, then all valid bits cleared; issue write same cycle is dropped.
//  - rst_i mid-operation: pending records discarded, outputs 0 next cycle.
// TESTING
//  - Reset: assert rst_i 2 cycles -> all outputs 0, err_o 0; first commit gets rvfi_order_o=0.
//  - Issue id3 insn 0x00A00093 rs1=5, commit port0 id3 rd=1 wdata=10 -> next cycle valid[0]=1, insn 0x00A00093, rd_wdata 10.
//  - Issue id1 load, LSU id1 vaddr 0x8000_0010 be 0x0F, commit -> rmask 0x0F, wmask 0, mem_addr 0x8000_0010.
//  - Dual commit ids 4,5 with order_q=7 -> orders 7 and 8; next single commit gets 9.
//  - ex_valid_i cause 2 on port0 with ack[1]=1 -> only lane0 valid, trap=1, cause=2, order+1.
//  - flush_i then commit id2 without re-issue -> record insn=0, err_o=1 and stays 1.

Source files
------------

// File: rtl/cva6_rvfi_probe_tracker.sv
// Rebuilds per-instruction RVFI retirement records from the issue, LSU and commit probes.
// A shadow table indexed by transaction ID is filled at issue/LSU time and read at commit.
module cva6_rvfi_probe_tracker #(
  parameter int unsigned NR_SB_ENTRIES   = 8,
  parameter int unsigned TRANS_ID_BITS   = 3,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned XLEN            = 64,
  parameter int unsigned PLEN            = 56
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               issue_ack_i,
  input  logic [TRANS_ID_BITS-1:0]           issue_pointer_i,
  input  logic [31:0]                        instruction_i,
  input  logic                               is_compressed_i,
  input  logic [XLEN-1:0]                    rs1_fwd_i,
  input  logic [XLEN-1:0]                    rs2_fwd_i,
  input  logic                               lsu_valid_i,
  input  logic [TRANS_ID_BITS-1:0]           lsu_trans_id_i,
  input  logic [XLEN-1:0]                    lsu_vaddr_i,
  input  logic [PLEN-1:0]                    lsu_paddr_i,
  input  logic [7:0]                         lsu_be_i,
  input  logic                               lsu_is_store_i,
  input  logic [NR_COMMIT_PORTS-1:0]         commit_ack_i,
  input  logic [NR_COMMIT_PORTS*TRANS_ID_BITS-1:0] commit_pointer_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]    commit_pc_i,
  input  logic [NR_COMMIT_PORTS*5-1:0]       commit_rd_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]    commit_wdata_i,
  input  logic                               ex_valid_i,
  input  logic [XLEN-1:0]                    ex_cause_i,
  input  logic [1:0]                         priv_lvl_i,
  input  logic                               debug_mode_i,
  output logic [NR_COMMIT_PORTS-1:0]         rvfi_valid_o,
  output logic [NR_COMMIT_PORTS*64-1:0]      rvfi_order_o,
  output logic [NR_COMMIT_PORTS*32-1:0]      rvfi_insn_o,
  output logic [NR_COMMIT_PORTS-1:0]         rvfi_trap_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]    rvfi_cause_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]    rvfi_pc_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]    rvfi_rs1_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]    rvfi_rs2_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]    rvfi_rd_wdata_o,
  output logic [NR_COMMIT_PORTS*5-1:0]       rvfi_rd_addr_o,
  output logic [NR_COMMIT_PORTS*2-1:0]       rvfi_mode_o,
  output logic [NR_COMMIT_PORTS-1:0]         rvfi_dbg_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]    rvfi_mem_addr_o,
  output logic [NR_COMMIT_PORTS*PLEN-1:0]    rvfi_mem_paddr_o,
  output logic [NR_COMMIT_PORTS*8-1:0]       rvfi_mem_rmask_o,
  output logic [NR_COMMIT_PORTS*8-1:0]       rvfi_mem_wmask_o,
  output logic                               err_o
);

  localparam int unsigned NP = NR_COMMIT_PORTS;

  logic [NR_SB_ENTRIES-1:0] ent_valid_q;
  logic [NR_SB_ENTRIES-1:0] ent_rvc_q;
  logic [31:0]              ent_insn_q  [NR_SB_ENTRIES];
  logic [XLEN-1:0]          ent_rs1_q   [NR_SB_ENTRIES];
  logic [XLEN-1:0]          ent_rs2_q   [NR_SB_ENTRIES];
  logic [XLEN-1:0]          ent_maddr_q [NR_SB_ENTRIES];
  logic [PLEN-1:0]          ent_paddr_q [NR_SB_ENTRIES];
  logic [7:0]               ent_rmask_q [NR_SB_ENTRIES];
  logic [7:0]               ent_wmask_q [NR_SB_ENTRIES];

  logic [63:0] order_q;
  logic        err_q;

  logic                     issue_wr_en;
  logic                     lsu_wr_en;
  logic [7:0]               lsu_rmask;
  logic [7:0]               lsu_wmask;
  logic [NP-1:0]            fire;
  logic [NP-1:0]            ack_eff;
  logic                     ack_gap;
  logic [TRANS_ID_BITS-1:0] lane_ptr [NP];
  logic [NP-1:0]            lane_hit;
  logic [NP-1:0]            lane_fwd;
  logic [63:0]              fire_cnt;

  logic [NP-1:0]      rec_valid, rec_trap, rec_dbg;
  logic [NP*64-1:0]   rec_order;
  logic [NP*32-1:0]   rec_insn;
  logic [NP*XLEN-1:0] rec_cause, rec_pc, rec_rs1, rec_rs2, rec_wdata, rec_maddr;
  logic [NP*PLEN-1:0] rec_paddr;
  logic [NP*5-1:0]    rec_rd;
  logic [NP*2-1:0]    rec_mode;
  logic [NP*8-1:0]    rec_rmask, rec_wmask;

  // An issue to the same ID in the same cycle overrides the LSU update.
  assign issue_wr_en = issue_ack_i && !flush_i;
  assign lsu_wr_en   = lsu_valid_i && !(issue_ack_i && (issue_pointer_i == lsu_trans_id_i));
  assign lsu_rmask   = lsu_is_store_i ? 8'h00 : lsu_be_i;
  assign lsu_wmask   = lsu_is_store_i ? lsu_be_i : 8'h00;
  assign err_o       = err_q;

  for (genvar g = 0; g < NP; g++) begin : g_lane
    assign lane_ptr[g] = commit_pointer_i[g*TRANS_ID_BITS +: TRANS_ID_BITS];
    assign lane_hit[g] = ent_valid_q[lane_ptr[g]];
    assign lane_fwd[g] = lsu_wr_en && (lsu_trans_id_i == lane_ptr[g]);
  end

  always_comb begin
    fire = commit_ack_i;
    if (ex_valid_i) begin
      fire    = '0;
      fire[0] = 1'b1;
    end
    ack_eff    = commit_ack_i;
    ack_eff[0] = commit_ack_i[0] | ex_valid_i;
    ack_gap    = 1'b0;
    for (int i = 1; i < NP; i++) begin
      if (ack_eff[i] && !ack_eff[i-1]) ack_gap = 1'b1;
    end
  end

  always_comb begin
    rec_valid = '0;  rec_trap  = '0;  rec_dbg   = '0;
    rec_order = '0;  rec_insn  = '0;  rec_cause = '0;
    rec_pc    = '0;  rec_rs1   = '0;  rec_rs2   = '0;
    rec_wdata = '0;  rec_maddr = '0;  rec_paddr = '0;
    rec_rd    = '0;  rec_mode  = '0;  rec_rmask = '0;
    rec_wmask = '0;  fire_cnt  = '0;
    for (int i = 0; i < NP; i++) begin
      if (fire[i]) begin
        rec_valid[i]              = 1'b1;
        rec_order[i*64 +: 64]     = order_q + fire_cnt;
        fire_cnt                  = fire_cnt + 64'd1;
        rec_pc[i*XLEN +: XLEN]    = commit_pc_i[i*XLEN +: XLEN];
        rec_mode[i*2 +: 2]        = priv_lvl_i;
        rec_dbg[i]                = debug_mode_i;
        // A stale entry yields an all-zero payload; err_o flags it.
        if (lane_hit[i]) begin
          rec_insn[i*32 +: 32]    = ent_rvc_q[lane_ptr[i]] ? {16'h0, ent_insn_q[lane_ptr[i]][15:0]}
                                                           : ent_insn_q[lane_ptr[i]];
          rec_rs1[i*XLEN +: XLEN] = ent_rs1_q[lane_ptr[i]];
          rec_rs2[i*XLEN +: XLEN] = ent_rs2_q[lane_ptr[i]];
          if (lane_fwd[i]) begin
            rec_maddr[i*XLEN +: XLEN] = lsu_vaddr_i;
            rec_paddr[i*PLEN +: PLEN] = lsu_paddr_i;
            rec_rmask[i*8 +: 8]       = lsu_rmask;
            rec_wmask[i*8 +: 8]       = lsu_wmask;
          end else begin
            rec_maddr[i*XLEN +: XLEN] = ent_maddr_q[lane_ptr[i]];
            rec_paddr[i*PLEN +: PLEN] = ent_paddr_q[lane_ptr[i]];
            rec_rmask[i*8 +: 8]       = ent_rmask_q[lane_ptr[i]];
            rec_wmask[i*8 +: 8]       = ent_wmask_q[lane_ptr[i]];
          end
        end
        if (i == 0 && ex_valid_i) begin
          rec_trap[i]               = 1'b1;
          rec_cause[i*XLEN +: XLEN] = ex_cause_i;
        end else begin
          rec_rd[i*5 +: 5] = commit_rd_i[i*5 +: 5];
          if (commit_rd_i[i*5 +: 5] != 5'd0) rec_wdata[i*XLEN +: XLEN] = commit_wdata_i[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_valid_q      <= '0;
      order_q          <= '0;
      err_q            <= 1'b0;
      rvfi_valid_o     <= '0;
      rvfi_order_o     <= '0;
      rvfi_insn_o      <= '0;
      rvfi_trap_o      <= '0;
      rvfi_cause_o     <= '0;
      rvfi_pc_o        <= '0;
      rvfi_rs1_o       <= '0;
      rvfi_rs2_o       <= '0;
      rvfi_rd_wdata_o  <= '0;
      rvfi_rd_addr_o   <= '0;
      rvfi_mode_o      <= '0;
      rvfi_dbg_o       <= '0;
      rvfi_mem_addr_o  <= '0;
      rvfi_mem_paddr_o <= '0;
      rvfi_mem_rmask_o <= '0;
      rvfi_mem_wmask_o <= '0;
    end else begin
      rvfi_valid_o     <= rec_valid;
      rvfi_order_o     <= rec_order;
      rvfi_insn_o      <= rec_insn;
      rvfi_trap_o      <= rec_trap;
      rvfi_cause_o     <= rec_cause;
      rvfi_pc_o        <= rec_pc;
      rvfi_rs1_o       <= rec_rs1;
      rvfi_rs2_o       <= rec_rs2;
      rvfi_rd_wdata_o  <= rec_wdata;
      rvfi_rd_addr_o   <= rec_rd;
      rvfi_mode_o      <= rec_mode;
      rvfi_dbg_o       <= rec_dbg;
      rvfi_mem_addr_o  <= rec_maddr;
      rvfi_mem_paddr_o <= rec_paddr;
      rvfi_mem_rmask_o <= rec_rmask;
      rvfi_mem_wmask_o <= rec_wmask;
      order_q          <= order_q + fire_cnt;
      if (|(fire & ~lane_hit)) err_q <= 1'b1;
      // Later assignments take priority: retire, then issue, then flush.
      for (int i = 0; i < NP; i++) begin
        if (fire[i]) ent_valid_q[lane_ptr[i]] <= 1'b0;
      end
      if (issue_wr_en) ent_valid_q[issue_pointer_i] <= 1'b1;
      if (flush_i) ent_valid_q <= '0;
    end
  end

  // Payload storage needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (lsu_wr_en) begin
      ent_maddr_q[lsu_trans_id_i] <= lsu_vaddr_i;
      ent_paddr_q[lsu_trans_id_i] <= lsu_paddr_i;
      ent_rmask_q[lsu_trans_id_i] <= lsu_rmask;
      ent_wmask_q[lsu_trans_id_i] <= lsu_wmask;
    end
    if (issue_wr_en) begin
      ent_insn_q[issue_pointer_i]  <= instruction_i;
      ent_rvc_q[issue_pointer_i]   <= is_compressed_i;
      ent_rs1_q[issue_pointer_i]   <= rs1_fwd_i;
      ent_rs2_q[issue_pointer_i]   <= rs2_fwd_i;
      ent_maddr_q[issue_pointer_i] <= '0;
      ent_paddr_q[issue_pointer_i] <= '0;
      ent_rmask_q[issue_pointer_i] <= '0;
      ent_wmask_q[issue_pointer_i] <= '0;
    end
  end

  ack_contiguous: assert property (@(posedge clk_i) disable iff (rst_i) !ack_gap);

endmodule

// File: tb/tb_cva6_rvfi_probe_tracker.sv
// Scoreboard bench for cva6_rvfi_probe_tracker: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the shadow table.
module tb_cva6_rvfi_probe_tracker;
  localparam int NP = 2, T = 3, XL = 64, PL = 56, NE = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_i, flush_i, issue_ack_i, is_compressed_i;
  logic [T-1:0]        issue_pointer_i, lsu_trans_id_i;
  logic [31:0]         instruction_i;
  logic [XL-1:0]       rs1_fwd_i, rs2_fwd_i, lsu_vaddr_i, ex_cause_i;
  logic                lsu_valid_i, lsu_is_store_i, ex_valid_i, debug_mode_i;
  logic [PL-1:0]       lsu_paddr_i;
  logic [7:0]          lsu_be_i;
  logic [NP-1:0]       commit_ack_i;
  logic [NP*T-1:0]     commit_pointer_i;
  logic [NP*XL-1:0]    commit_pc_i, commit_wdata_i;
  logic [NP*5-1:0]     commit_rd_i;
  logic [1:0]          priv_lvl_i;
  logic [NP-1:0]       rvfi_valid_o, rvfi_trap_o, rvfi_dbg_o;
  logic [NP*64-1:0]    rvfi_order_o;
  logic [NP*32-1:0]    rvfi_insn_o;
  logic [NP*XL-1:0]    rvfi_cause_o, rvfi_pc_o, rvfi_rs1_o, rvfi_rs2_o, rvfi_rd_wdata_o, rvfi_mem_addr_o;
  logic [NP*5-1:0]     rvfi_rd_addr_o;
  logic [NP*2-1:0]     rvfi_mode_o;
  logic [NP*PL-1:0]    rvfi_mem_paddr_o;
  logic [NP*8-1:0]     rvfi_mem_rmask_o, rvfi_mem_wmask_o;
  logic                err_o;

  cva6_rvfi_probe_tracker dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_ack_i(issue_ack_i), .issue_pointer_i(issue_pointer_i), .instruction_i(instruction_i),
    .is_compressed_i(is_compressed_i), .rs1_fwd_i(rs1_fwd_i), .rs2_fwd_i(rs2_fwd_i),
    .lsu_valid_i(lsu_valid_i), .lsu_trans_id_i(lsu_trans_id_i), .lsu_vaddr_i(lsu_vaddr_i),
    .lsu_paddr_i(lsu_paddr_i), .lsu_be_i(lsu_be_i), .lsu_is_store_i(lsu_is_store_i),
    .commit_ack_i(commit_ack_i), .commit_pointer_i(commit_pointer_i), .commit_pc_i(commit_pc_i),
    .commit_rd_i(commit_rd_i), .commit_wdata_i(commit_wdata_i), .ex_valid_i(ex_valid_i),
    .ex_cause_i(ex_cause_i), .priv_lvl_i(priv_lvl_i), .debug_mode_i(debug_mode_i),
    .rvfi_valid_o(rvfi_valid_o), .rvfi_order_o(rvfi_order_o), .rvfi_insn_o(rvfi_insn_o),
    .rvfi_trap_o(rvfi_trap_o), .rvfi_cause_o(rvfi_cause_o), .rvfi_pc_o(rvfi_pc_o),
    .rvfi_rs1_o(rvfi_rs1_o), .rvfi_rs2_o(rvfi_rs2_o), .rvfi_rd_wdata_o(rvfi_rd_wdata_o),
    .rvfi_rd_addr_o(rvfi_rd_addr_o), .rvfi_mode_o(rvfi_mode_o), .rvfi_dbg_o(rvfi_dbg_o),
    .rvfi_mem_addr_o(rvfi_mem_addr_o), .rvfi_mem_paddr_o(rvfi_mem_paddr_o),
    .rvfi_mem_rmask_o(rvfi_mem_rmask_o), .rvfi_mem_wmask_o(rvfi_mem_wmask_o), .err_o(err_o)
  );

  typedef struct {
    bit v; bit rvc; bit [31:0] insn; bit [63:0] rs1, rs2, maddr; bit [55:0] paddr; bit [7:0] rmask, wmask;
  } ent_t;
  typedef struct {
    int lane; bit [63:0] order; bit [31:0] insn; bit trap; bit [63:0] cause, pc, rs1, rs2, wdata, maddr;
    bit [55:0] paddr; bit [4:0] rd; bit [1:0] mode; bit dbg; bit [7:0] rmask, wmask;
  } rec_t;

  ent_t       tbl [NE];
  bit [63:0]  m_order;
  bit         m_err;
  rec_t       exp_q [$];
  int         n_cmp = 0, n_bad = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: read the table as it stood before this cycle (plus same-cycle LSU data),
  // then apply LSU, retirements, issue and flush in that order of precedence.
  task automatic model_step();
    ent_t e; rec_t r; bit [T-1:0] p; bit lsu_over; bit [NP-1:0] fired;
    if (rst_i) begin
      foreach (tbl[k]) tbl[k].v = 1'b0;
      m_order = 0; m_err = 0; exp_q.delete();
      return;
    end
    lsu_over = issue_ack_i && (issue_pointer_i == lsu_trans_id_i);
    fired = ex_valid_i ? NP'(1) : commit_ack_i;
    for (int i = 0; i < NP; i++) begin
      if (fired[i]) begin
        p = commit_pointer_i[i*T +: T];
        e = tbl[p];
        if (lsu_valid_i && !lsu_over && lsu_trans_id_i == p) begin
          e.maddr = lsu_vaddr_i; e.paddr = lsu_paddr_i;
          e.rmask = lsu_is_store_i ? 8'h0 : lsu_be_i;
          e.wmask = lsu_is_store_i ? lsu_be_i : 8'h0;
        end
        r = '{default: 0};
        r.lane = i; r.order = m_order; m_order = m_order + 1;
        r.pc = commit_pc_i[i*XL +: XL]; r.mode = priv_lvl_i; r.dbg = debug_mode_i;
        if (e.v) begin
          r.insn = e.rvc ? {16'h0, e.insn[15:0]} : e.insn;
          r.rs1 = e.rs1; r.rs2 = e.rs2; r.maddr = e.maddr; r.paddr = e.paddr;
          r.rmask = e.rmask; r.wmask = e.wmask;
        end else m_err = 1'b1;
        if (i == 0 && ex_valid_i) begin
          r.trap = 1'b1; r.cause = ex_cause_i;
        end else begin
          r.rd = commit_rd_i[i*5 +: 5];
          r.wdata = (r.rd == 5'd0) ? 64'd0 : commit_wdata_i[i*XL +: XL];
        end
        exp_q.push_back(r);
      end
    end
    if (lsu_valid_i && !lsu_over) begin
      tbl[lsu_trans_id_i].maddr = lsu_vaddr_i; tbl[lsu_trans_id_i].paddr = lsu_paddr_i;
      tbl[lsu_trans_id_i].rmask = lsu_is_store_i ? 8'h0 : lsu_be_i;
      tbl[lsu_trans_id_i].wmask = lsu_is_store_i ? lsu_be_i : 8'h0;
    end
    for (int i = 0; i < NP; i++) if (fired[i]) tbl[commit_pointer_i[i*T +: T]].v = 1'b0;
    if (issue_ack_i && !flush_i)
      tbl[issue_pointer_i] = '{v: 1'b1, rvc: is_compressed_i, insn: instruction_i, rs1: rs1_fwd_i,
                               rs2: rs2_fwd_i, maddr: 64'd0, paddr: 56'd0, rmask: 8'd0, wmask: 8'd0};
    if (flush_i) foreach (tbl[k]) tbl[k].v = 1'b0;
  endtask

  always @(posedge clk) begin
    rec_t r;
    #1;
    if (mon_en) begin
      for (int i = 0; i < NP; i++) begin
        if (rvfi_valid_o[i]) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_record lane %0d: got valid 1 expected 0", i);
          end else begin
            r = exp_q.pop_front();
            chk("lane",   64'(i),                          64'(r.lane));
            chk("order",  rvfi_order_o[i*64 +: 64],         r.order);
            chk("insn",   64'(rvfi_insn_o[i*32 +: 32]),     64'(r.insn));
            chk("trap",   64'(rvfi_trap_o[i]),              64'(r.trap));
            chk("cause",  rvfi_cause_o[i*XL +: XL],         r.cause);
            chk("pc",     rvfi_pc_o[i*XL +: XL],            r.pc);
            chk("rs1",    rvfi_rs1_o[i*XL +: XL],           r.rs1);
            chk("rs2",    rvfi_rs2_o[i*XL +: XL],           r.rs2);
            chk("rd",     64'(rvfi_rd_addr_o[i*5 +: 5]),    64'(r.rd));
            chk("wdata",  rvfi_rd_wdata_o[i*XL +: XL],      r.wdata);
            chk("mode",   64'(rvfi_mode_o[i*2 +: 2]),       64'(r.mode));
            chk("dbg",    64'(rvfi_dbg_o[i]),               64'(r.dbg));
            chk("maddr",  rvfi_mem_addr_o[i*XL +: XL],      r.maddr);
            chk("paddr",  64'(rvfi_mem_paddr_o[i*PL +: PL]), 64'(r.paddr));
            chk("rmask",  64'(rvfi_mem_rmask_o[i*8 +: 8]),  64'(r.rmask));
            chk("wmask",  64'(rvfi_mem_wmask_o[i*8 +: 8]),  64'(r.wmask));
          end
        end
      end
      chk("pending_records", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      chk("err_o", 64'(err_o), 64'(m_err));
    end
  end

  task automatic idle();
    rst_i = 0; flush_i = 0; issue_ack_i = 0; issue_pointer_i = 0; instruction_i = 0; is_compressed_i = 0;
    rs1_fwd_i = 0; rs2_fwd_i = 0; lsu_valid_i = 0; lsu_trans_id_i = 0; lsu_vaddr_i = 0; lsu_paddr_i = 0;
    lsu_be_i = 0; lsu_is_store_i = 0; commit_ack_i = 0; commit_pointer_i = 0; commit_pc_i = 0;
    commit_rd_i = 0; commit_wdata_i = 0; ex_valid_i = 0; ex_cause_i = 0; priv_lvl_i = 2'd3; debug_mode_i = 0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input logic [T-1:0] id, input logic [31:0] insn, input logic rvc,
                       input logic [63:0] a, input logic [63:0] b);
    issue_ack_i = 1; issue_pointer_i = id; instruction_i = insn; is_compressed_i = rvc;
    rs1_fwd_i = a; rs2_fwd_i = b;
  endtask

  task automatic lsu(input logic [T-1:0] id, input logic [63:0] va, input logic [55:0] pa,
                     input logic [7:0] be, input logic st);
    lsu_valid_i = 1; lsu_trans_id_i = id; lsu_vaddr_i = va; lsu_paddr_i = pa; lsu_be_i = be; lsu_is_store_i = st;
  endtask

  task automatic commit(input int lane, input logic [T-1:0] id, input logic [63:0] pc,
                        input logic [4:0] rd, input logic [63:0] wd);
    commit_ack_i[lane] = 1'b1; commit_pointer_i[lane*T +: T] = id;
    commit_pc_i[lane*XL +: XL] = pc; commit_rd_i[lane*5 +: 5] = rd; commit_wdata_i[lane*XL +: XL] = wd;
  endtask

  task automatic rand_cycle();
    int n;
    logic [T-1:0] p0;
    if ($urandom_range(0, 149) == 0) begin rst_i = 1; return; end
    if ($urandom_range(0, 3) != 0)
      issue(T'($urandom), $urandom, ($urandom_range(0, 3) == 0), {$urandom, $urandom}, {$urandom, $urandom});
    if ($urandom_range(0, 2) == 0)
      lsu(T'($urandom), {$urandom, $urandom}, {24'($urandom), $urandom}, 8'($urandom), 1'($urandom));
    n = $urandom_range(0, 2);
    p0 = T'($urandom);
    for (int i = 0; i < n; i++)
      commit(i, p0 + T'(i), {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             {$urandom, $urandom});
    if ($urandom_range(0, 9) == 0) begin
      ex_valid_i = 1; ex_cause_i = {$urandom, $urandom};
      commit_ack_i = NP'($urandom);
      commit_pointer_i[T-1:0] = p0; commit_pointer_i[2*T-1:T] = p0 + T'(1);
    end
    if ($urandom_range(0, 24) == 0) flush_i = 1;
    priv_lvl_i = 2'($urandom); debug_mode_i = 1'($urandom);
    if (issue_ack_i && lsu_valid_i && issue_pointer_i == lsu_trans_id_i &&
        (lsu_trans_id_i == p0 || lsu_trans_id_i == p0 + T'(1)))
      lsu_valid_i = 0;
  endtask

  initial begin
    idle();
    @(negedge clk);
    rst_i = 1; tick();
    rst_i = 1; tick();
    mon_en = 1;
    chk("rst_valid", 64'(rvfi_valid_o), 64'd0);
    chk("rst_order0", rvfi_order_o[63:0], 64'd0);
    chk("rst_insn", 64'(rvfi_insn_o), 64'd0);
    chk("rst_trap", 64'(rvfi_trap_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);

    issue(3, 32'h00A00093, 0, 64'd5, 64'd0); tick();
    commit(0, 3, 64'h8000_0000, 5'd1, 64'd10); tick();
    chk("addi_valid", 64'(rvfi_valid_o), 64'h1);
    chk("addi_insn", 64'(rvfi_insn_o[31:0]), 64'h00A00093);
    chk("addi_wdata", rvfi_rd_wdata_o[63:0], 64'd10);
    chk("addi_rs1", rvfi_rs1_o[63:0], 64'd5);
    chk("addi_order", rvfi_order_o[63:0], 64'd0);

    issue(1, 32'h00052503, 0, 64'h8000_0000, 64'd0); tick();
    lsu(1, 64'h8000_0010, 56'h8000_0010, 8'h0F, 0); tick();
    commit(0, 1, 64'h8000_0004, 5'd10, 64'h1234); tick();
    chk("load_rmask", 64'(rvfi_mem_rmask_o[7:0]), 64'h0F);
    chk("load_wmask", 64'(rvfi_mem_wmask_o[7:0]), 64'h00);
    chk("load_maddr", rvfi_mem_addr_o[63:0], 64'h8000_0010);
    chk("load_order", rvfi_order_o[63:0], 64'd1);

    for (int k = 0; k < 5; k++) begin
      issue(6, 32'h00000013, 0, 64'd0, 64'd0); tick();
      commit(0, 6, 64'h100 + 64'(k), 5'd0, 64'd0); tick();
    end
    issue(4, 32'h00100113, 0, 64'd1, 64'd2); tick();
    issue(5, 32'h00200193, 0, 64'd3, 64'd4); tick();
    commit(0, 4, 64'h200, 5'd2, 64'd1); commit(1, 5, 64'h204, 5'd3, 64'd2); tick();
    chk("dual_valid", 64'(rvfi_valid_o), 64'h3);
    chk("dual_order0", rvfi_order_o[63:0], 64'd7);
    chk("dual_order1", rvfi_order_o[127:64], 64'd8);
    issue(0, 32'h00000013, 0, 64'd0, 64'd0); tick();
    commit(0, 0, 64'h208, 5'd0, 64'd0); tick();
    chk("single_order", rvfi_order_o[63:0], 64'd9);

    issue(7, 32'h00000073, 0, 64'd0, 64'd0); tick();
    commit(0, 7, 64'h20C, 5'd4, 64'd9); commit(1, 6, 64'h210, 5'd5, 64'd9);
    ex_valid_i = 1; ex_cause_i = 64'd2; tick();
    chk("ex_valid", 64'(rvfi_valid_o), 64'h1);
    chk("ex_trap", 64'(rvfi_trap_o), 64'h1);
    chk("ex_cause", rvfi_cause_o[63:0], 64'd2);
    chk("ex_wdata", rvfi_rd_wdata_o[63:0], 64'd0);
    chk("ex_order", rvfi_order_o[63:0], 64'd10);
    chk("ex_err", 64'(err_o), 64'd0);

    issue(5, 32'h00B52023, 0, 64'h10, 64'h20); tick();
    lsu(5, 64'h9000_0040, 56'h9000_0040, 8'hF0, 1); commit(0, 5, 64'h214, 5'd0, 64'h77); tick();
    chk("fwd_wmask", 64'(rvfi_mem_wmask_o[7:0]), 64'hF0);
    chk("fwd_rmask", 64'(rvfi_mem_rmask_o[7:0]), 64'h00);
    chk("fwd_maddr", rvfi_mem_addr_o[63:0], 64'h9000_0040);
    chk("rd0_wdata", rvfi_rd_wdata_o[63:0], 64'd0);
    issue(4, 32'hABCD4501, 1, 64'd0, 64'd0); tick();
    commit(0, 4, 64'h218, 5'd10, 64'd1); tick();
    chk("rvc_insn", 64'(rvfi_insn_o[31:0]), 64'h00004501);

    issue(2, 32'h00000013, 0, 64'd0, 64'd0); tick();
    flush_i = 1; issue(3, 32'h00000013, 0, 64'd0, 64'd0); tick();
    commit(0, 2, 64'h21C, 5'd1, 64'd1); tick();
    chk("flush_insn", 64'(rvfi_insn_o[31:0]), 64'd0);
    chk("flush_err", 64'(err_o), 64'd1);
    commit(0, 3, 64'h220, 5'd1, 64'd1); tick();
    chk("flush_issue_dropped", 64'(rvfi_insn_o[31:0]), 64'd0);
    tick(); tick(); tick();
    chk("err_sticky", 64'(err_o), 64'd1);

    issue(3, 32'h00000013, 0, 64'd0, 64'd0); tick();
    commit(0, 3, 64'h224, 5'd1, 64'd1); rst_i = 1; tick();
    chk("midrst_valid", 64'(rvfi_valid_o), 64'd0);
    chk("midrst_err", 64'(err_o), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      rand_cycle(); tick();
    end
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
